// File: rtl/lif_neuron_layer.sv
// Layer of leaky integrate-and-fire neurons with a serial configuration chain.
// Optional refractory counters are enabled by defining LIF_REFRACTORY_EN.
module lif_neuron_layer #(
    parameter int WIDTH    = 8,
    parameter int WEIGHT_W = 4,
    parameter int POT_W    = 8,
    parameter int REFRACT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic             cfg_in,
    output logic             cfg_out,
    input  logic             step,
    input  logic [WIDTH-1:0] spike_in,
    output logic [WIDTH-1:0] spike_out
);
    localparam int CFG_BITS   = 3 * WEIGHT_W + POT_W + 3;
    localparam int CHAIN_BITS = WIDTH * CFG_BITS;
    localparam int SUM_W      = POT_W + 2;

    if (REFRACT < 0) begin : g_bad_refract
        $error("REFRACT must be non-negative");
    end

    logic [CHAIN_BITS-1:0] chain;
    logic [WIDTH+1:0]      spike_pad;
    logic [WIDTH-1:0]      fire;

    // Zero pads at both ends stop the edge neurons from seeing a wrapped neighbour.
    assign spike_pad = {1'b0, spike_in, 1'b0};

    function automatic logic signed [SUM_W-1:0] gated(input logic en,
                                                      input logic signed [WEIGHT_W-1:0] w);
        return en ? {{(SUM_W - WEIGHT_W){w[WEIGHT_W-1]}}, w} : '0;
    endfunction

    // NOTE: sequential state uses <= so every neuron sees the same pre-edge chain and potentials.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         chain <= '0;
        else if (cfg_en) chain <= {chain[CHAIN_BITS-2:0], cfg_in};
    end

    assign cfg_out = chain[CHAIN_BITS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   spike_out <= '0;
        else if (cfg_en || !step)  spike_out <= '0;
        else                       spike_out <= fire;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_neuron
        logic signed [WEIGHT_W-1:0] wl, wc, wr;
        logic signed [POT_W-1:0]    thr, pot, pot_sat;
        logic [2:0]                 leak;
        logic signed [SUM_W-1:0]    pot_ext, stim, decay, pot_raw;
        logic                       refractory;

        assign {wl, wc, wr, thr, leak} = chain[i*CFG_BITS +: CFG_BITS];
        assign pot_ext = {{2{pot[POT_W-1]}}, pot};
        assign stim    = gated(spike_pad[i], wl) + gated(spike_pad[i+1], wc)
                       + gated(spike_pad[i+2], wr);

        // NOTE: each always_comb output gets a default first, so no latch is inferred.
        always_comb begin
            decay = '0;
            if (leak != 3'd0) decay = pot_ext >>> leak;
        end

        assign pot_raw = pot_ext - decay + stim;

        // Clamp when the guard bits disagree with the POT_W sign bit.
        always_comb begin
            pot_sat = pot_raw[POT_W-1:0];
            if (pot_raw[SUM_W-1:POT_W-1] != '0 && pot_raw[SUM_W-1:POT_W-1] != '1)
                pot_sat = pot_raw[SUM_W-1] ? {1'b1, {(POT_W-1){1'b0}}}
                                           : {1'b0, {(POT_W-1){1'b1}}};
        end

        assign fire[i] = !refractory && (pot_sat > thr);

        always_ff @(posedge clk or posedge rst) begin
            if (rst)         pot <= '0;
            else if (cfg_en) pot <= '0;
            else if (step)   pot <= (fire[i] || refractory) ? '0 : pot_sat;
        end

`ifdef LIF_REFRACTORY_EN
        localparam int CNT_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
        logic [CNT_W-1:0] cnt;

        assign refractory = (cnt != '0);

        always_ff @(posedge clk or posedge rst) begin
            if (rst)         cnt <= '0;
            else if (cfg_en) cnt <= '0;
            else if (step) begin
                if (refractory)   cnt <= cnt - 1'b1;
                else if (fire[i]) cnt <= CNT_W'(REFRACT);
            end
        end
`else
        assign refractory = 1'b0;
`endif
    end
endmodule

// File: doc/lif_neuron_layer.md
# lif_neuron_layer

Parametrised layer of leaky integrate-and-fire neurons. It is the successor to the single-bit shift-memory neuron array. Each neuron keeps a signed membrane potential and integrates weighted spikes from itself and its two nearest neighbours in the previous layer. It applies a per-neuron leak, fires when the potential crosses a per-neuron threshold, and honours an optional refractory period. Weights, thresholds and leak are loaded through a serial configuration chain. Layers are cascaded by connecting one layer's SPIKE_OUT to the next layer's SPIKE_IN.

## Interface
- WIDTH, 8: neurons in the layer, and also the SPIKE_IN width.
- WEIGHT_W, 4: signed two's-complement width of each weight.
- POT_W, 8: signed width of the potential and of the threshold.
- REFRACT, 2: refractory length in STEPs, used only with LIF_REFRACTORY_EN.
- CLK  in  1  clock; every flop changes on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- CFG_EN  in  1  configuration shift enable.
- CFG_IN  in  1  configuration serial data in.
- CFG_OUT  out  1  configuration serial data out, used for readback and daisy-chaining.
- STEP  in  1  timestep strobe; one integrate/fire update per cycle in which it is high.
- SPIKE_IN  in  WIDTH  input spikes from the previous layer, sampled on STEP.
- SPIKE_OUT  out  WIDTH  output spikes, registered, one-cycle pulse.

## Operation
- Per-neuron config word, CFG_BITS = 3*WEIGHT_W+POT_W+3 bits (23 at defaults). Fields, MSB to LSB:
  - wl: weight for the left neighbour.
  - wc: weight for the neuron's own input.
  - wr: weight for the right neighbour.
  - thr: signed threshold.
  - leak: 3 bits.
- Configuration chain:
  - The chain is {cfg[WIDTH-1],…,cfg[0]}.
  - When CFG_EN=1, each cycle does chain <= {chain[MSB-1:0], CFG_IN}.
  - CFG_OUT = chain[MSB] at all times.
- While CFG_EN=1:
  - Potentials and refractory counters are forced to 0.
  - SPIKE_OUT is 0.
  - STEP is ignored, so CFG_EN wins over a simultaneous STEP.
- Update on STEP=1 with CFG_EN=0, for each neuron i:
  - Weighted input: s = wl·SPIKE_IN[i-1] + wc·SPIKE_IN[i] + wr·SPIKE_IN[i+1].
  - Edges do not wrap. i-1 for neuron 0 and i+1 for neuron WIDTH-1 contribute 0.
  - Leak: leak=0 means no decay (d=0). leak=L in 1..7 means d = v>>>L (arithmetic shift).
  - New potential: v' = v − d + s. Compute at POT_W+2 bits, then saturate to [−2^(POT_W−1), 2^(POT_W−1)−1]. The potential never wraps.
  - Fire test: v' > thr, strictly greater and signed.
  - On fire: SPIKE_OUT[i]=1 and v=0. The refractory counter loads REFRACT if the feature is enabled.
  - Otherwise: v=v'.
- Refractory neuron (counter≠0) on a STEP: the counter decrements, v is held at 0, there is no spike, and input is discarded.
- STEP=0: v and the counters hold; SPIKE_OUT=0.
- Reset values:
  - Chain is all zeros: weights 0, thr 0, leak 0.
  - Potentials and counters are 0.
  - SPIKE_OUT=0 and CFG_OUT=0.
  - With zero config, no neuron ever fires, because 0 > 0 is false.
- RST mid-operation, including mid-shift, discards all state immediately. A partial config load is lost and must be repeated in full.

## Timing
- SPIKE_OUT is valid in the cycle after a STEP cycle and is high for exactly 1 cycle. With back-to-back STEPs, a neuron can pulse on consecutive cycles.
- Config shift has 1 bit/cycle latency. A full load takes WIDTH·CFG_BITS cycles (184 at defaults).
- CFG_OUT presents bit k of the shifted stream WIDTH·CFG_BITS cycles after it entered.
- There is no combinational path from any input to any output.

## Configuration
- LIF_REFRACTORY_EN:
  - Defined: each neuron has a $clog2(REFRACT+1)-bit counter. After firing on STEP k, STEPs k+1…k+REFRACT are suppressed, and the neuron is eligible again on STEP k+REFRACT+1.
  - Undefined: there are no counters, REFRACT is ignored, and a neuron may fire on every STEP.

## Test plan
- **Reset:** pulse RST during a config shift, then apply STEP with SPIKE_IN=8'hFF for 10 cycles. Required: SPIKE_OUT=0 throughout and CFG_OUT=0.
- **Readback:** shift a 184-bit pseudo-random pattern P, then shift 184 zeros. Required: CFG_OUT replays P in order, first bit first, starting on the first zero-shift cycle.
- **Integrate and fire:** neuron 3 has wc=+3, thr=7, leak=0, and SPIKE_IN[3]=1 on every STEP. Required: v goes 3, 6, 9, so SPIKE_OUT[3] pulses after the 3rd STEP only; with the macro off it pulses again after the 6th.
- **Leak:** neuron 2 has wc=+4, thr=100, leak=1, with constant input. Required: v goes 4, 6, 7, 8, 8…, and there is never a spike.
- **Edges:** neuron 0 has wl=+7 and neuron 7 has wr=+7; both have wc=0, thr=0; SPIKE_IN=8'hFF for 20 STEPs. Required: SPIKE_OUT[0]=SPIKE_OUT[7]=0 throughout.
- **Refractory, macro on:** REFRACT=2, neuron 5 has wc=+7, thr=6, constant input. Required: spikes after STEPs 1, 4, 7, 10. With the macro off: a spike after every STEP.
